mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 20 ++
 rtl/mem_access_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - memory-side request/response bus between the MEM-stage controller and memory
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store sequencer with byte lanes, timeout and writeback register
module mem_access_ctrl (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              is_nop_mem,
  input  logic              register_write_mem,
  input  logic [1:0]        register_src_mem,
  input  logic              we_memory_mem,
  input  logic              is_word_mem,
  input  logic [31:0]       ALU_result_mem,
  input  logic [31:0]       rt_data_mem,
  input  logic [4:0]        rd_num_mem,
  input  logic              halted_controller_mem,
  mem_access_ctrl_if.master mem,
  output logic              lock,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              halted_wb,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [5:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        st_q, st_d;
  logic        word_q, word_d;
  logic [1:0]  sel_q, sel_d;
  logic        rw_q, rw_d;
  logic [4:0]  rd_q, rd_d;
  logic        halt_q, halt_d;
  logic        tmo_q, tmo_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        halted_wb_q, halted_wb_d;
  logic        err_q, err_d;

  logic        op_ld, op_st, op_mem, aligned, start, misalign;
  logic        acked, timeout;
  logic [7:0]  ld_byte;
  logic [31:0] ld_word;

  // A slot that is both load and store is handled as a store: op_st drives mem_we.
  assign op_ld    = !is_nop_mem && (register_src_mem == 2'b01);
  assign op_st    = !is_nop_mem && we_memory_mem;
  assign op_mem   = op_ld || op_st;
  assign aligned  = !is_word_mem || (ALU_result_mem[1:0] == 2'b00);
  assign start    = op_mem && aligned;
  assign misalign = op_mem && !aligned;

  // An ack in the final wait cycle wins over the timeout.
  assign acked   = (state_q == S_ACCESS) && mem.mem_ack;
  assign timeout = (state_q == S_ACCESS) && !mem.mem_ack && (wait_q == 6'd63);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'b0000;
      wait_q      <= 6'd0;
      rdata_q     <= 32'h0;
      st_q        <= 1'b0;
      word_q      <= 1'b0;
      sel_q       <= 2'b00;
      rw_q        <= 1'b0;
      rd_q        <= 5'd0;
      halt_q      <= 1'b0;
      tmo_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
      halted_wb_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      wait_q      <= wait_d;
      rdata_q     <= rdata_d;
      st_q        <= st_d;
      word_q      <= word_d;
      sel_q       <= sel_d;
      rw_q        <= rw_d;
      rd_q        <= rd_d;
      halt_q      <= halt_d;
      tmo_q       <= tmo_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      halted_wb_q <= halted_wb_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCESS;
      S_ACCESS: if (acked || timeout) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    wait_d      = wait_q;
    rdata_d     = rdata_q;
    st_d        = st_q;
    word_d      = word_q;
    sel_d       = sel_q;
    rw_d        = rw_q;
    rd_d        = rd_q;
    halt_d      = halt_q;
    tmo_d       = tmo_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    halted_wb_d = 1'b0;
    err_d       = err_q;
    lock        = 1'b0;
    ld_byte     = rdata_q[{sel_q, 3'b000} +: 8];
    ld_word     = word_q ? rdata_q : {{24{ld_byte[7]}}, ld_byte};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Slot fields are captured so the bus stays stable even if upstream changes.
          lock    = rst_b;
          req_d   = 1'b1;
          we_d    = op_st;
          addr_d  = {ALU_result_mem[31:2], 2'b00};
          wdata_d = !op_st      ? 32'h0 :
                    is_word_mem ? rt_data_mem : {4{rt_data_mem[7:0]}};
          be_d    = is_word_mem ? 4'b1111 : (4'b0001 << ALU_result_mem[1:0]);
          wait_d  = 6'd0;
          st_d    = op_st;
          word_d  = is_word_mem;
          sel_d   = ALU_result_mem[1:0];
          rw_d    = register_write_mem;
          rd_d    = rd_num_mem;
          halt_d  = halted_controller_mem;
          tmo_d   = 1'b0;
        end else begin
          wb_valid_d  = !is_nop_mem;
          wb_we_d     = register_write_mem && !is_nop_mem && !misalign;
          wb_rd_d     = rd_num_mem;
          wb_data_d   = ALU_result_mem;
          halted_wb_d = halted_controller_mem;
          if (misalign) err_d = 1'b1;
        end
      end
      S_ACCESS: begin
        lock = rst_b;
        if (acked) begin
          req_d   = 1'b0;
          rdata_d = mem.mem_rdata;
        end else if (timeout) begin
          req_d = 1'b0;
          err_d = 1'b1;
          tmo_d = 1'b1;
        end else begin
          wait_d = wait_q + 6'd1;
        end
      end
      S_DONE: begin
        wb_valid_d  = 1'b1;
        wb_we_d     = rw_q && !st_q && !tmo_q;
        wb_rd_d     = rd_q;
        wb_data_d   = (st_q || tmo_q) ? 32'h0 : ld_word;
        halted_wb_d = halt_q;
      end
      default: ;
    endcase
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign wb_valid      = wb_valid_q;
  assign wb_we         = wb_we_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign halted_wb     = halted_wb_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with directed load/store/ALU slots
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        is_nop_mem, register_write_mem, we_memory_mem, is_word_mem, halted_controller_mem;
  logic [1:0]  register_src_mem;
  logic [31:0] ALU_result_mem, rt_data_mem;
  logic [4:0]  rd_num_mem;
  logic        lock, wb_valid, wb_we, halted_wb, mem_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_ctrl_if bus();
  logic        resp_ack, force_ack;
  logic [31:0] rdata_v;
  int          ack_delay, ack_cnt;
  assign bus.mem_ack   = resp_ack | force_ack;
  assign bus.mem_rdata = rdata_v;

  mem_access_ctrl dut (
    .clk(clk), .rst_b(rst_b), .is_nop_mem(is_nop_mem), .register_write_mem(register_write_mem),
    .register_src_mem(register_src_mem), .we_memory_mem(we_memory_mem), .is_word_mem(is_word_mem),
    .ALU_result_mem(ALU_result_mem), .rt_data_mem(rt_data_mem), .rd_num_mem(rd_num_mem),
    .halted_controller_mem(halted_controller_mem), .mem(bus), .lock(lock), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .halted_wb(halted_wb), .mem_err(mem_err)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; logic we; logic halt; logic chk_data; } wb_exp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic chk_wd; } bus_exp_t;
  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_delay wait cycles (never when negative).
  initial begin
    resp_ack = 1'b0;
    ack_cnt  = 0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        resp_ack = (ack_cnt == ack_delay);
        ack_cnt++;
      end else begin
        resp_ack = 1'b0;
        ack_cnt  = 0;
      end
    end
  end

  initial begin : wb_monitor
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (wb_q.size() == 0) chk("wb_unexpected_valid", {31'b0, wb_valid}, 32'h0);
        else begin
          e = wb_q.pop_front();
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk("wb_we", {31'b0, wb_we}, {31'b0, e.we});
          chk("halted_wb", {31'b0, halted_wb}, {31'b0, e.halt});
          if (e.chk_data) chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  initial begin : bus_monitor
    bus_exp_t    b;
    logic        p_req, p_we;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_be;
    p_req = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wdata = 32'h0; p_be = 4'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (!p_req) begin
          if (bus_q.size() == 0) chk("req_unexpected", {31'b0, bus.mem_req}, 32'h0);
          else begin
            b = bus_q.pop_front();
            chk("mem_we", {31'b0, bus.mem_we}, {31'b0, b.we});
            chk("mem_addr", bus.mem_addr, b.addr);
            if (b.chk_wd) begin
              chk("mem_be", {28'b0, bus.mem_be}, {28'b0, b.be});
              chk("mem_wdata", bus.mem_wdata, b.wdata);
            end
          end
        end else begin
          chk("stable_addr", bus.mem_addr, p_addr);
          chk("stable_we_be", {27'b0, bus.mem_we, bus.mem_be}, {27'b0, p_we, p_be});
          chk("stable_wdata", bus.mem_wdata, p_wdata);
        end
      end
      p_req = (bus.mem_req === 1'b1); p_we = bus.mem_we; p_addr = bus.mem_addr;
      p_wdata = bus.mem_wdata; p_be = bus.mem_be;
    end
  end

  task automatic set_idle();
    is_nop_mem = 1'b1; register_write_mem = 1'b0; register_src_mem = 2'b00; we_memory_mem = 1'b0;
    is_word_mem = 1'b0; ALU_result_mem = 32'h0; rt_data_mem = 32'h0; rd_num_mem = 5'd0;
    halted_controller_mem = 1'b0;
  endtask

  task automatic set_slot(input logic nop, input logic rw, input logic [1:0] src, input logic wem,
                          input logic wrd, input logic [31:0] alu, input logic [31:0] rt,
                          input logic [4:0] rd, input logic halt);
    is_nop_mem = nop; register_write_mem = rw; register_src_mem = src; we_memory_mem = wem;
    is_word_mem = wrd; ALU_result_mem = alu; rt_data_mem = rt; rd_num_mem = rd;
    halted_controller_mem = halt;
  endtask

  // Holds the slot until lock drops; edges counts clock edges consumed by the slot.
  task automatic run_slot(input logic nop, input logic rw, input logic [1:0] src, input logic wem,
                          input logic wrd, input logic [31:0] alu, input logic [31:0] rt,
                          input logic [4:0] rd, input logic halt, output int edges, output int locked);
    logic l;
    set_slot(nop, rw, src, wem, wrd, alu, rt, rd, halt);
    edges = 0; locked = 0;
    do begin
      #1; l = lock;
      if (l) locked++;
      @(posedge clk); @(negedge clk);
      edges++;
    end while (l && edges < 300);
    if (l) chk("slot_lock_hang", {31'b0, l}, 32'h0);
    set_idle();
  endtask

  task automatic do_load(input logic wrd, input logic [31:0] addr, input logic [31:0] rdata,
                         input int delay, input logic [4:0] rd, input logic halt,
                         input logic [31:0] exp_data, input logic [31:0] exp_addr,
                         output int edges, output int locked);
    rdata_v = rdata; ack_delay = delay;
    bus_q.push_back('{1'b0, exp_addr, 4'h0, 32'h0, 1'b0});
    wb_q.push_back('{rd, exp_data, 1'b1, halt, 1'b1});
    run_slot(1'b0, 1'b1, 2'b01, 1'b0, wrd, addr, 32'h0, rd, halt, edges, locked);
  endtask

  task automatic do_store(input logic wrd, input logic ld_too, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [4:0] rd, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata, output int edges);
    int lk;
    ack_delay = 1;
    bus_q.push_back('{1'b1, exp_addr, exp_be, exp_wdata, 1'b1});
    wb_q.push_back('{rd, 32'h0, 1'b0, 1'b0, 1'b0});
    run_slot(1'b0, 1'b1, ld_too ? 2'b01 : 2'b00, 1'b1, wrd, addr, rt, rd, 1'b0, edges, lk);
  endtask

  initial begin
    int e, lk;
    rst_b = 1'b0; force_ack = 1'b0; rdata_v = 32'h0; ack_delay = 0;
    set_idle();
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    chk("rst_lock", {31'b0, lock}, 32'h0);
    chk("rst_wb", {26'b0, wb_valid, wb_we, wb_rd}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_halt_err", {30'b0, halted_wb, mem_err}, 32'h0);
    rst_b = 1'b1;

    wb_q.push_back('{5'd5, 32'h42, 1'b1, 1'b0, 1'b1});
    run_slot(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h42, 32'h0, 5'd5, 1'b0, e, lk);
    chk("alu_edges", e, 1);
    chk("alu_lock_cycles", lk, 0);

    do_load(1'b1, 32'h100, 32'hDEAD_BEEF, 2, 5'd7, 1'b0, 32'hDEAD_BEEF, 32'h100, e, lk);
    chk("wload_edges", e, 5);
    chk("wload_lock_cycles", lk, 4);
    do_load(1'b1, 32'h104, 32'h0BAD_F00D, 0, 5'd9, 1'b1, 32'h0BAD_F00D, 32'h104, e, lk);
    chk("wload_0ws_edges", e, 3);

    do_store(1'b0, 1'b0, 32'h203, 32'h0000_00A5, 5'd3, 32'h200, 4'b1000, 32'hA5A5_A5A5, e);
    chk("bstore_edges", e, 4);
    do_store(1'b1, 1'b0, 32'h300, 32'hCAFE_F00D, 5'd4, 32'h300, 4'b1111, 32'hCAFE_F00D, e);
    do_store(1'b0, 1'b0, 32'h200, 32'h1234_5611, 5'd8, 32'h200, 4'b0001, 32'h1111_1111, e);
    do_store(1'b1, 1'b1, 32'h400, 32'h1357_2468, 5'd10, 32'h400, 4'b1111, 32'h1357_2468, e);

    do_load(1'b0, 32'h201, 32'h0000_8000, 1, 5'd11, 1'b0, 32'hFFFF_FF80, 32'h200, e, lk);
    do_load(1'b0, 32'h200, 32'h1234_5678, 0, 5'd12, 1'b0, 32'h0000_0078, 32'h200, e, lk);
    do_load(1'b0, 32'h203, 32'h7F00_0000, 0, 5'd13, 1'b0, 32'h0000_007F, 32'h200, e, lk);
    do_load(1'b0, 32'h202, 32'h00AB_0000, 0, 5'd14, 1'b0, 32'hFFFF_FFAB, 32'h200, e, lk);

    run_slot(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 32'h500, 32'h0, 5'd15, 1'b0, e, lk);
    chk("nop_lock_cycles", lk, 0);

    wb_q.push_back('{5'd16, 32'h1234_5678, 1'b1, 1'b1, 1'b1});
    run_slot(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 5'd16, 1'b1, e, lk);
    force_ack = 1'b1;
    wb_q.push_back('{5'd17, 32'hFFFF_0001, 1'b0, 1'b0, 1'b1});
    run_slot(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'hFFFF_0001, 32'h0, 5'd17, 1'b0, e, lk);
    force_ack = 1'b0;
    chk("stray_ack_no_req", {31'b0, bus.mem_req}, 32'h0);
    chk("err_clear_before_misalign", {31'b0, mem_err}, 32'h0);

    wb_q.push_back('{5'd20, 32'h0, 1'b0, 1'b0, 1'b0});
    run_slot(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h102, 32'h0, 5'd20, 1'b0, e, lk);
    chk("misalign_edges", e, 1);
    chk("misalign_lock_cycles", lk, 0);
    chk("misalign_err", {31'b0, mem_err}, 32'h1);
    wb_q.push_back('{5'd21, 32'h0, 1'b0, 1'b0, 1'b0});
    run_slot(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h301, 32'h77, 5'd21, 1'b0, e, lk);
    wb_q.push_back('{5'd22, 32'h99, 1'b1, 1'b0, 1'b1});
    run_slot(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h99, 32'h0, 5'd22, 1'b0, e, lk);
    chk("err_sticky", {31'b0, mem_err}, 32'h1);

    rst_b = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", {31'b0, mem_err}, 32'h0);
    rst_b = 1'b1;
    @(negedge clk);

    do_load(1'b1, 32'h600, 32'h55AA_55AA, 63, 5'd4, 1'b0, 32'h55AA_55AA, 32'h600, e, lk);
    chk("ack_at_limit_edges", e, 66);
    chk("ack_at_limit_no_err", {31'b0, mem_err}, 32'h0);

    ack_delay = -1;
    bus_q.push_back('{1'b0, 32'h700, 4'h0, 32'h0, 1'b0});
    wb_q.push_back('{5'd6, 32'h0, 1'b0, 1'b0, 1'b0});
    run_slot(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h700, 32'h0, 5'd6, 1'b0, e, lk);
    chk("timeout_edges", e, 66);
    chk("timeout_lock_cycles", lk, 65);
    chk("timeout_err", {31'b0, mem_err}, 32'h1);
    wb_q.push_back('{5'd1, 32'h5, 1'b1, 1'b0, 1'b1});
    run_slot(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h5, 32'h0, 5'd1, 1'b0, e, lk);
    chk("after_timeout_alu_edges", e, 1);

    bus_q.push_back('{1'b0, 32'h100, 4'h0, 32'h0, 1'b0});
    set_slot(1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'h100, 32'h0, 5'd2, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("pre_reset_req", {31'b0, bus.mem_req}, 32'h1);
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    chk("midreset_req", {31'b0, bus.mem_req}, 32'h0);
    chk("midreset_lock", {31'b0, lock}, 32'h0);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    do_load(1'b1, 32'h100, 32'hDEAD_BEEF, 2, 5'd7, 1'b0, 32'hDEAD_BEEF, 32'h100, e, lk);
    chk("post_reset_load_edges", e, 5);

    repeat (3) @(negedge clk);
    chk("wb_queue_left", wb_q.size(), 0);
    chk("bus_queue_left", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
